// File: rtl/fpu_div_seq.sv
// Sequential signed fixed-point divider: quotient = dividend / divisor.
// Restoring radix-2 division on magnitudes, one quotient bit per CALC cycle,
// followed by sign fixup and saturation to the signed WIDTH-bit range.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE. The
// result and flags hold steady while out_valid is high and out_ready is low.
module fpu_div_seq #(
  parameter int FRAC_BITS = 48,
  parameter int WIDTH     = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int ITER = WIDTH + FRAC_BITS;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  // Numerator bits leave at the top while quotient bits enter at the bottom;
  // after ITER shifts this register holds the full magnitude quotient.
  logic [ITER-1:0]  work;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] div_mag;
  logic             sign;

  logic             accept;
  logic             div_is_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_nxt;
  logic [ITER-1:0]  work_nxt;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign state_dbg   = state;
  assign accept      = in_valid && in_ready;
  assign div_is_zero = (divisor == '0);
  // Unsigned magnitudes: the most negative operand maps exactly onto 2^(W-1).
  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a zero divisor skips the iteration entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = div_is_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step plus the sign fixup and saturation of the final quotient.
  always_comb begin
    rem_sh   = {rem[WIDTH-1:0], work[ITER-1]};
    diff     = rem_sh - {1'b0, div_mag};
    q_bit    = ~diff[WIDTH];
    rem_nxt  = q_bit ? diff : rem_sh;
    work_nxt = {work[ITER-2:0], q_bit};
    pos_ovf  = |work_nxt[ITER-1:WIDTH-1];
    neg_ovf  = (|work_nxt[ITER-1:WIDTH]) |
               (work_nxt[WIDTH-1] & (|work_nxt[WIDTH-2:0]));
    res      = work_nxt[WIDTH-1:0];
    res_ovf  = 1'b0;
    if (sign) begin
      res_ovf = neg_ovf;
      res     = neg_ovf ? MIN_NEG : (~work_nxt[WIDTH-1:0] + 1'b1);
    end else begin
      res_ovf = pos_ovf;
      res     = pos_ovf ? MAX_POS : work_nxt[WIDTH-1:0];
    end
  end

  // Datapath: operand capture, iteration, and result registers written only
  // when entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      work     <= '0;
      rem      <= '0;
      div_mag  <= '0;
      sign     <= 1'b0;
      quotient <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      work    <= {a_mag, {FRAC_BITS{1'b0}}};
      rem     <= '0;
      div_mag <= b_mag;
      sign    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      if (div_is_zero) begin
        quotient <= dividend[WIDTH-1] ? MIN_NEG : MAX_POS;
        div_zero <= 1'b1;
        overflow <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt  <= cnt - 1'b1;
      work <= work_nxt;
      rem  <= rem_nxt;
      if (cnt == '0) begin
        quotient <= res;
        div_zero <= 1'b0;
        overflow <= res_ovf;
      end
    end
  end

endmodule

// File: doc/fpu_div_seq.md
FPU_DIV_SEQ -- requirements
Module: fpu_div_seq

Interface
REQ-001 SHALL provide parameter FRAC_BITS, default 48, the number of fractional bits of the signed fixed-point format (one = 64'h0001000000000000).
REQ-002 SHALL provide parameter WIDTH, default 64, the operand and result width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dividend  input  64  signed fixed-point a, taken from the FPU input mux.
REQ-008 divisor  input  64  signed fixed-point b, taken from the FPU input mux.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  64  signed fixed-point a/b.
REQ-012 div_zero  output  1  divisor was zero; valid with out_valid.
REQ-013 overflow  output  1  result saturated; valid with out_valid.

Function
REQ-014 SHALL implement states IDLE, CALC and DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL assert out_valid only in DONE.
REQ-017 SHALL latch operands on in_valid && in_ready (edge N).
REQ-018 On that edge it SHALL store |a|, |b| and sign = a[63]^b[63].
REQ-019 The stored magnitudes SHALL be 64-bit unsigned, so that |-2^63| = 2^63 is exact.
REQ-020 SHALL compute magnitude Q = floor((|a| << FRAC_BITS) / |b|) by radix-2 restoring division over WIDTH+FRAC_BITS = 112 iterations, one quotient bit per CALC cycle, MSB first.
REQ-021 SHALL use a 7-bit down-counter, loaded with 111 on accept, with IDLE->CALC at edge N and CALC->DONE at the edge where the counter equals 0.
REQ-022 out_valid SHALL first be high in the cycle after edge N+112 (fixed latency 113 edges).
REQ-023 If divisor == 0 at accept, SHALL go IDLE->DONE directly at edge N, so out_valid is high after edge N.
REQ-024 On divisor == 0 it SHALL set div_zero=1 and overflow=0.
REQ-025 On divisor == 0 the quotient SHALL be 64'h7FFF_FFFF_FFFF_FFFF when dividend >= 0, else 64'h8000_0000_0000_0000.
REQ-026 Sign fixup: result = sign ? -Q : Q, truncating toward zero.
REQ-027 If sign=0 and Q > 2^63-1, SHALL output 64'h7FFF_FFFF_FFFF_FFFF with overflow=1.
REQ-028 If sign=1 and Q > 2^63, SHALL output 64'h8000_0000_0000_0000 with overflow=1.
REQ-029 Q == 2^63 with sign=1 SHALL yield 64'h8000_0000_0000_0000 with overflow=0.
REQ-030 Zero dividend SHALL give quotient 0, including the case of a negative divisor (no -0 concerns).
REQ-031 quotient and the flags SHALL hold stable while out_valid && !out_ready.
REQ-032 DONE->IDLE SHALL occur on out_valid && out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-033 in_valid SHALL be ignored outside IDLE.
REQ-034 Operand inputs SHALL be ignored after accept.
REQ-035 quotient, div_zero and overflow SHALL be registered.
REQ-036 These registered outputs SHALL be written only on the CALC->DONE or IDLE->DONE transition.

Reset
REQ-037 reset_n low SHALL immediately force IDLE, counter=0, quotient=0, div_zero=0, overflow=0 and out_valid=0.
REQ-038 After reset_n deasserts, in_ready SHALL be 1.
REQ-039 Reset asserted mid-CALC or in DONE SHALL discard the operation.
REQ-040 After reset, no out_valid SHALL appear until a new accept.

Verification
REQ-041 Identity: a=64'h0001_0000_0000_0000, b=64'h0001_0000_0000_0000, out_ready=1 -> quotient 64'h0001_0000_0000_0000, flags 0, out_valid exactly 113 edges after accept, high one cycle.
REQ-042 Signed: a=64'hFFFD_0000_0000_0000 (-3.0), b=64'h0002_0000_0000_0000 (2.0) -> 64'hFFFE_8000_0000_0000 (-1.5), flags 0.
REQ-043 Divide by zero: a=64'hFFFF_0000_0000_0000 (-1.0), b=0 -> 64'h8000_0000_0000_0000, div_zero=1, out_valid one edge after accept.
REQ-044 Overflow: a=64'h4000_0000_0000_0000, b=64'h0000_0000_0000_0001 -> 64'h7FFF_FFFF_FFFF_FFFF, overflow=1; and a=64'h8000_0000_0000_0000, b=64'h0001_0000_0000_0000 -> 64'h8000_0000_0000_0000, overflow=0.
REQ-045 Backpressure: hold out_ready=0 for 5 cycles in DONE -> quotient and flags constant, in_ready=0, new in_valid ignored; on out_ready=1, IDLE next cycle.
REQ-046 Reset mid-op: assert reset_n=0 asynchronously 40 cycles into CALC -> outputs zero without waiting for a clock edge, in_ready=1 after release, next operation 1.0/1.0 correct.
